// File: rtl/forwarding_source.sv
// Forwarding source: tracks producer registers in EX/MEM/WB and presents
// their live results, readiness and the multiply/divide freeze request.
package forwarding_pkg;
    typedef logic [4:0]  reg_t;
    typedef logic [31:0] int_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_ALU    = 2'd1,
        CLS_LOAD   = 2'd2,
        CLS_MULDIV = 2'd3
    } class_t;

    typedef struct packed {
        reg_t regDest;
        logic dataReady;
        int_t forwardingData;
    } forwarding_data_t;

    typedef forwarding_data_t [2:0] forwarding_datas_t;

    typedef struct packed {
        reg_t   dest;
        class_t cls;
    } slot_t;

    localparam slot_t HOLLOW = '{dest: 5'd0, cls: CLS_NONE};
endpackage

module forwarding_source
    import forwarding_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issueValid,
    input  reg_t              issueRegDest,
    input  logic [1:0]        issueClass,
    input  logic              hazardStall,
    input  logic              flush,
    input  int_t              exResult,
    input  int_t              memResult,
    input  int_t              wbResult,
    output forwarding_datas_t forwardingDatas,
    output logic              stallOut
);
    localparam logic [3:0] MD_LOAD = 4'(MULDIV_LATENCY - 1);

    typedef enum logic [1:0] {
        MODE_ADVANCE,
        MODE_BUBBLE,
        MODE_FREEZE
    } mode_t;

    slot_t [2:0] slots;
    slot_t [2:0] slots_next;
    slot_t       issue_slot;
    logic  [3:0] md_count;
    logic  [3:0] md_next;
    mode_t       mode;
    class_t      issue_cls;
    int_t        buses [3];

    assign issue_cls = class_t'(issueClass);
    assign buses[0]  = exResult;
    assign buses[1]  = memResult;
    assign buses[2]  = wbResult;

    assign stallOut = (slots[0].cls == CLS_MULDIV) && (md_count != 4'd0);

    always_comb begin
        issue_slot = HOLLOW;
        if (issueValid && issue_cls != CLS_NONE && issueRegDest != 5'd0) begin
            issue_slot = '{dest: issueRegDest, cls: issue_cls};
        end
    end

    always_comb begin
        mode = MODE_ADVANCE;
        if (stallOut) begin
            mode = MODE_FREEZE;
        end else if (hazardStall || flush) begin
            mode = MODE_BUBBLE;
        end
    end

    always_comb begin
        slots_next = slots;
        md_next    = (md_count != 4'd0) ? md_count - 4'd1 : 4'd0;
        unique case (mode)
            MODE_FREEZE: begin
                // The multi-cycle op stays in EX while older work drains.
                slots_next[2] = slots[1];
                slots_next[1] = HOLLOW;
            end
            MODE_BUBBLE: begin
                slots_next[2] = slots[1];
                slots_next[1] = slots[0];
                slots_next[0] = HOLLOW;
            end
            MODE_ADVANCE: begin
                slots_next[2] = slots[1];
                slots_next[1] = slots[0];
                slots_next[0] = issue_slot;
                if (issue_slot.cls == CLS_MULDIV) begin
                    md_next = MD_LOAD;
                end
            end
            default: begin
                slots_next = slots;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slots    <= {HOLLOW, HOLLOW, HOLLOW};
            md_count <= 4'd0;
        end else begin
            slots    <= slots_next;
            md_count <= md_next;
        end
    end

    always_comb begin
        forwardingDatas = '0;
        for (int i = 0; i < 3; i++) begin
            forwardingDatas[i].regDest = slots[i].dest;
            forwardingDatas[i].forwardingData =
                (slots[i].cls == CLS_NONE) ? 32'd0 : buses[i];
            forwardingDatas[i].dataReady = 1'b1;
            unique case (slots[i].cls)
                CLS_LOAD:   forwardingDatas[i].dataReady = (i == 2);
                CLS_MULDIV: forwardingDatas[i].dataReady =
                                (i != 0) || (md_count == 4'd0);
                default:    forwardingDatas[i].dataReady = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_forwarding_source.sv
// Bench for forwarding_source: directed scenarios with literal expectations
// plus a per-cycle comparison against a slot-list reference model.
module tb_forwarding_source;
    import forwarding_pkg::*;

    localparam int LAT = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              issueValid = 1'b0;
    reg_t              issueRegDest = '0;
    logic [1:0]        issueClass = '0;
    logic              hazardStall = 1'b0;
    logic              flush = 1'b0;
    int_t              exResult = 32'h11;
    int_t              memResult = 32'h22;
    int_t              wbResult = 32'h33;
    forwarding_datas_t forwardingDatas;
    logic              stallOut;

    int tests = 0;
    int fails = 0;

    forwarding_source #(.MULDIV_LATENCY(LAT)) dut (
        .clock          (clock),
        .reset          (reset),
        .issueValid     (issueValid),
        .issueRegDest   (issueRegDest),
        .issueClass     (issueClass),
        .hazardStall    (hazardStall),
        .flush          (flush),
        .exResult       (exResult),
        .memResult      (memResult),
        .wbResult       (wbResult),
        .forwardingDatas(forwardingDatas),
        .stallOut       (stallOut)
    );

    always #5 clock = ~clock;

    // Reference: list of (dest, class) for EX, MEM, WB plus cycles left
    int m_dest [3] = '{0, 0, 0};
    int m_cls  [3] = '{0, 0, 0};
    int m_left = 0;

    always @(posedge clock or posedge reset) begin
        bit busy;
        bit hole;
        if (reset) begin
            m_dest = '{0, 0, 0};
            m_cls  = '{0, 0, 0};
            m_left = 0;
        end else begin
            busy = (m_cls[0] == 3) && (m_left > 0);
            hole = !issueValid || issueClass == 2'd0 || issueRegDest == 5'd0;
            m_dest[2] = m_dest[1];
            m_cls[2]  = m_cls[1];
            if (busy) begin
                m_dest[1] = 0;
                m_cls[1]  = 0;
            end else begin
                m_dest[1] = m_dest[0];
                m_cls[1]  = m_cls[0];
                if (hazardStall || flush || hole) begin
                    m_dest[0] = 0;
                    m_cls[0]  = 0;
                end else begin
                    m_dest[0] = int'(issueRegDest);
                    m_cls[0]  = int'(issueClass);
                end
            end
            if (!busy && !(hazardStall || flush) && !hole && issueClass == 2'd3)
                m_left = LAT - 1;
            else if (m_left > 0)
                m_left = m_left - 1;
        end
    end

    function automatic forwarding_datas_t model_out();
        forwarding_datas_t e;
        int_t bus [3];
        bus[0] = exResult;
        bus[1] = memResult;
        bus[2] = wbResult;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            e[i].regDest = 5'(m_dest[i]);
            if (m_cls[i] == 0) begin
                e[i].dataReady = 1'b1;
                e[i].forwardingData = 32'd0;
            end else begin
                e[i].forwardingData = bus[i];
                if (m_cls[i] == 2)
                    e[i].dataReady = (i == 2);
                else if (m_cls[i] == 3 && i == 0)
                    e[i].dataReady = (m_left == 0);
                else
                    e[i].dataReady = 1'b1;
            end
        end
        return e;
    endfunction

    always @(negedge clock) begin
        forwarding_datas_t e;
        bit es;
        e  = model_out();
        es = (m_cls[0] == 3) && (m_left > 0);
        tests++;
        if (forwardingDatas !== e) begin
            fails++;
            $display("FAIL model_fd t=%0t got %h expected %h",
                     $time, forwardingDatas, e);
        end
        tests++;
        if (stallOut !== es) begin
            fails++;
            $display("FAIL model_stall t=%0t got %b expected %b",
                     $time, stallOut, es);
        end
    end

    task automatic chk_slot(string name, int i, int dest, bit rdy, int_t data);
        forwarding_data_t want;
        want = '{regDest: 5'(dest), dataReady: rdy, forwardingData: data};
        tests++;
        if (forwardingDatas[i] !== want) begin
            fails++;
            $display("FAIL %s slot%0d got {%0d,%b,%h} expected {%0d,%b,%h}",
                     name, i, forwardingDatas[i].regDest,
                     forwardingDatas[i].dataReady,
                     forwardingDatas[i].forwardingData, dest, rdy, data);
        end
    endtask

    task automatic chk_stall(string name, bit want);
        tests++;
        if (stallOut !== want) begin
            fails++;
            $display("FAIL %s stallOut got %b expected %b", name, stallOut, want);
        end
    endtask

    task automatic set_issue(bit v, int cls, int dest);
        issueValid   = v;
        issueClass   = 2'(cls);
        issueRegDest = 5'(dest);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk_slot("reset", i, 0, 1'b1, 32'd0);
        chk_stall("reset", 1'b0);
        tick();
        reset = 1'b0;

        // ALU chain
        set_issue(1, 1, 5);
        tick();
        chk_slot("alu_ex", 0, 5, 1'b1, 32'h11);
        set_issue(0, 0, 0);
        tick();
        chk_slot("alu_mem", 1, 5, 1'b1, 32'h22);
        chk_slot("alu_ex_hollow", 0, 0, 1'b1, 32'd0);
        tick();
        chk_slot("alu_wb", 2, 5, 1'b1, 32'h33);

        // Load-use
        set_issue(1, 2, 8);
        tick();
        chk_slot("load_ex", 0, 8, 1'b0, 32'h11);
        hazardStall = 1'b1;
        set_issue(1, 1, 9);
        tick();
        chk_slot("load_bubble", 0, 0, 1'b1, 32'd0);
        chk_slot("load_mem", 1, 8, 1'b0, 32'h22);
        hazardStall = 1'b0;
        set_issue(0, 0, 0);
        tick();
        chk_slot("load_wb", 2, 8, 1'b1, 32'h33);

        // MULDIV freeze, with flush/stall ignored while frozen
        set_issue(1, 3, 3);
        tick();
        chk_stall("md_c1", 1'b1);
        chk_slot("md_c1", 0, 3, 1'b0, 32'h11);
        set_issue(0, 0, 0);
        tick();
        chk_stall("md_c2", 1'b1);
        chk_slot("md_c2_mem", 1, 0, 1'b1, 32'd0);
        flush = 1'b1;
        hazardStall = 1'b1;
        set_issue(1, 1, 9);
        tick();
        chk_stall("md_c3", 1'b1);
        chk_slot("md_frozen", 0, 3, 1'b0, 32'h11);
        flush = 1'b0;
        hazardStall = 1'b0;
        set_issue(0, 0, 0);
        tick();
        chk_stall("md_done", 1'b0);
        chk_slot("md_done", 0, 3, 1'b1, 32'h11);

        // Back-to-back MULDIV
        set_issue(1, 3, 4);
        tick();
        chk_stall("md2_start", 1'b1);
        chk_slot("md2_ex", 0, 4, 1'b0, 32'h11);
        chk_slot("md2_prev", 1, 3, 1'b1, 32'h22);
        set_issue(0, 0, 0);
        tick();
        tick();
        tick();
        chk_stall("md2_done", 1'b0);

        // Hollow issues
        set_issue(1, 0, 10);
        tick();
        chk_slot("none_class", 0, 0, 1'b1, 32'd0);
        chk_slot("md2_mem", 1, 4, 1'b1, 32'h22);
        set_issue(1, 1, 0);
        tick();
        chk_slot("r0_dest", 0, 0, 1'b1, 32'd0);

        // Flush of an issuing ALU op
        set_issue(1, 1, 9);
        flush = 1'b1;
        tick();
        chk_slot("flush_ex", 0, 0, 1'b1, 32'd0);
        flush = 1'b0;
        set_issue(0, 0, 0);
        tick();
        chk_slot("flush_mem", 1, 0, 1'b1, 32'd0);
        tick();
        chk_slot("flush_wb", 2, 0, 1'b1, 32'd0);

        // Reset in the middle of a MULDIV
        set_issue(1, 3, 6);
        tick();
        set_issue(0, 0, 0);
        tick();
        chk_stall("pre_reset", 1'b1);
        #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk_slot("async_reset", i, 0, 1'b1, 32'd0);
        chk_stall("async_reset", 1'b0);
        tick();
        reset = 1'b0;
        set_issue(1, 1, 7);
        tick();
        chk_slot("post_reset", 0, 7, 1'b1, 32'h11);
        chk_stall("post_reset", 1'b0);

        // Mixed traffic checked by the model
        for (int n = 0; n < 300; n++) begin
            set_issue(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 31)));
            hazardStall = ($urandom_range(0, 7) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            exResult    = $urandom;
            memResult   = $urandom;
            wbResult    = $urandom;
            if (n == 150) begin
                reset = 1'b1;
                #1;
                reset = 1'b0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/forwarding_source.md
FORWARDING_SOURCE -- requirements
Module: forwarding_source

Interface
REQ-001 SHALL have parameter: MULDIV_LATENCY, default 4, EX-stage cycles for a multiply/divide result (legal 1..15).
REQ-002 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have port: issueValid  input  1  decode presents an instruction to enter EX this cycle.
REQ-005 SHALL have port: issueRegDest  input  reg_t (5)  destination register of the issuing instruction.
REQ-006 SHALL have port: issueClass  input  2  producer class: 0 NONE, 1 ALU, 2 LOAD, 3 MULDIV.
REQ-007 SHALL have port: hazardStall  input  1  stall from the forwarding/hazard logic; decode held, bubble into EX.
REQ-008 SHALL have port: flush  input  1  discard the instruction currently issuing (branch redirect).
REQ-009 SHALL have port: exResult, memResult, wbResult  input  int_t (32) each  live result buses of EX, MEM, WB.
REQ-010 SHALL have port: forwardingDatas  output  forwarding_datas_t (3 x {regDest, dataReady, forwardingData})  slot 0 = EX, 1 = MEM, 2 = WB.
REQ-011 SHALL have port: stallOut  output  1  pipeline freeze request while a MULDIV occupies EX and is not finished.

Function
REQ-012 SHALL hold three registered slots (EX, MEM, WB), each storing regDest and class; forwardingData is not stored.
REQ-013 SHALL define a hollow slot as regDest = 0, class NONE, presented as dataReady = 1, forwardingData = 0.
REQ-014 SHALL drive forwardingData of slot 0/1/2 combinationally from exResult/memResult/wbResult, forced to 0 when the slot is hollow.
REQ-015 SHALL drive dataReady combinationally: slot 0 -- ALU 1, LOAD 0, MULDIV (mdCount == 0); slot 1 -- ALU 1, MULDIV 1, LOAD 0; slot 2 -- always 1; NONE always 1.
REQ-016 SHALL treat an issue as hollow when issueValid = 0, issueClass = NONE, or issueRegDest = 0.
REQ-017 SHALL, per clock edge, apply exactly one mode in priority: FREEZE (stallOut = 1), then BUBBLE (hazardStall = 1 or flush = 1), then ADVANCE.
REQ-018 SHALL in FREEZE: slot 0 holds, slot 2 <= slot 1, slot 1 <= hollow; issue, hazardStall and flush ignored.
REQ-019 SHALL in BUBBLE: slot 2 <= slot 1, slot 1 <= slot 0, slot 0 <= hollow; issue discarded.
REQ-020 SHALL in ADVANCE: slot 2 <= slot 1, slot 1 <= slot 0, slot 0 <= issue (or hollow per REQ-016).
REQ-021 SHALL keep a 4-bit counter mdCount: on ADVANCE loading a MULDIV issue, mdCount <= MULDIV_LATENCY - 1; otherwise decrement when nonzero; never wrap below 0.
REQ-022 SHALL drive stallOut = (slot 0 class == MULDIV) and (mdCount != 0), combinationally from registered state.
REQ-023 SHALL, with MULDIV_LATENCY = 1, never assert stallOut and treat a MULDIV exactly as ALU.
REQ-024 SHALL allow a new MULDIV to issue on the edge where mdCount reaches 0, with no idle cycle between back-to-back MULDIVs.
REQ-025 SHALL allow two slots to hold the same regDest; priority among them is resolved by the consumer (lowest slot index wins).

Reset
REQ-026 SHALL on reset = 1, without waiting for a clock, set all three slots hollow and mdCount = 0, so forwardingDatas are all {0,1,0} and stallOut = 0.
REQ-027 SHALL, on reset asserted mid-MULDIV, drop stallOut in the same cycle and resume ADVANCE on the first edge after reset deasserts.

Verification
REQ-028 SHALL cover ALU chain: issue ALU r5, exResult = 0x11 -> slot 0 {5,1,0x11}; next edge slot 1 {5,1,memResult}; next slot 2 {5,1,wbResult}.
REQ-029 SHALL cover load-use: issue LOAD r8 -> slot 0 {8,0}; hazardStall = 1 one cycle -> slot 0 hollow, slot 1 {8,0}; next edge slot 2 {8,1,wbResult}.
REQ-030 SHALL cover MULDIV (latency 4): issue MULDIV r3 -> stallOut = 1 for 3 cycles with slot 0 {3,0}, slot 1 hollow after the first edge; 4th cycle stallOut = 0, slot 0 {3,1,exResult}.
REQ-031 SHALL cover flush with issueValid = 1, ALU r9 -> slot 0 hollow after edge; r9 appears in no slot.
REQ-032 SHALL cover flush and hazardStall during FREEZE -> no effect; slot 0 still MULDIV, mdCount continues counting.
REQ-033 SHALL cover reset mid-MULDIV (mdCount = 2) -> outputs all {0,1,0} and stallOut = 0 before the next edge.
